// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D line-memory arbiter.
package cache_arb_pkg;

    localparam int ADDR_W        = 32;
    localparam int LINE_W        = 256;
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef enum logic {
        ARB_I,
        ARB_D
    } arb_id_t;

    // Memory works on whole lines, so the byte offset is always dropped.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter bundled into one interface.
interface cache_mem_arbiter_if
    import cache_arb_pkg::*;
;
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    // slave is the arbiter's view; master is the surrounding caches and memory.
    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and D-cache.
module cache_mem_arbiter
    import cache_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        next_state;
    arb_id_t           owner;
    arb_id_t           last_grant;
    arb_id_t           grant_id;
    logic              grant;
    logic              op_write;
    logic              i_req;
    logic              d_req;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] held_wdata;
    logic [LINE_W-1:0] line_buf;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from state only, so an async reset drops them immediately.
    always_comb begin
        next_state    = state;
        grant         = 1'b0;
        grant_id      = ARB_I;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_resp    = 1'b0;
        bus.d_resp    = 1'b0;
        bus.i_rdata   = '0;
        bus.d_rdata   = '0;
        unique case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant    = 1'b1;
                    grant_id = (last_grant == ARB_I) ? ARB_D : ARB_I;
                end else if (i_req) begin
                    grant    = 1'b1;
                    grant_id = ARB_I;
                end else if (d_req) begin
                    grant    = 1'b1;
                    grant_id = ARB_D;
                end
                if (grant) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_read  = ~op_write;
                bus.mem_write = op_write;
                bus.mem_addr  = line_addr;
                bus.mem_wdata = held_wdata;
                if (bus.mem_resp) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state  = IDLE;
                bus.i_resp  = (owner == ARB_I);
                bus.d_resp  = (owner == ARB_D);
                bus.i_rdata = line_buf;
                bus.d_rdata = line_buf;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A simultaneous D read+write is taken as a write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= ARB_I;
            last_grant <= ARB_I;
            op_write   <= 1'b0;
            line_addr  <= '0;
            held_wdata <= '0;
            line_buf   <= '0;
        end else begin
            if (grant) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                op_write   <= (grant_id == ARB_D) && bus.d_write;
                line_addr  <= line_align((grant_id == ARB_D) ? bus.d_addr : bus.i_addr);
                if ((grant_id == ARB_D) && bus.d_write) begin
                    held_wdata <= bus.d_wdata;
                end
            end
            if ((state == ISSUE) && bus.mem_resp && !op_write) begin
                line_buf <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter with a transaction-level reference model.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   viol_count;

    // Reference model: who won the last grant (1 = D) and the last line read from memory.
    bit                model_last_d;
    logic [LINE_W-1:0] model_line;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst && bus.d_read && bus.d_write) begin
            viol_count++;
            $display("[TB] protocol violation: d_read and d_write asserted together");
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 32; w++) begin
            l[32*w +: 32] = $urandom;
        end
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit ir, input logic [ADDR_W-1:0] ia, input bit dr,
                                 input bit dw, input logic [ADDR_W-1:0] da,
                                 input logic [LINE_W-1:0] dwd);
        bus.i_read  = ir;
        bus.i_addr  = ia;
        bus.d_read  = dr;
        bus.d_write = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, ".mem_read"},  bus.mem_read,  0);
        checkOutput({tag, ".mem_write"}, bus.mem_write, 0);
        checkOutput({tag, ".mem_addr"},  bus.mem_addr,  0);
        checkOutput({tag, ".i_resp"},    bus.i_resp,    0);
        checkOutput({tag, ".d_resp"},    bus.d_resp,    0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst          = 1'b1;
        bus.mem_resp = 1'b0;
        #1;
        check_quiet("reset");
        checkOutput("reset.mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset.i_rdata",   bus.i_rdata,   0);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        model_last_d = 1'b0;
        model_line   = '0;
    endtask

    // One arbitrated transaction; requests must already be applied while the DUT is idle.
    task automatic do_txn(input int k, input bit wiggle, input bit spurious);
        bit                win_d;
        bit                exp_wr;
        bit                ir;
        bit                dr;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata;
        logic [LINE_W-1:0] rline;
        ir = bus.i_read;
        dr = bus.d_read | bus.d_write;
        if (ir && dr) win_d = !model_last_d;
        else          win_d = dr;
        exp_wr       = win_d && bus.d_write;
        exp_addr     = (win_d ? bus.d_addr : bus.i_addr) & 32'hFFFF_FFE0;
        exp_wdata    = bus.d_wdata;
        model_last_d = win_d;

        @(posedge clk);
        @(negedge clk);
        checkOutput("issue.mem_read",  bus.mem_read,  !exp_wr);
        checkOutput("issue.mem_write", bus.mem_write, exp_wr);
        checkOutput("issue.mem_addr",  bus.mem_addr,  exp_addr);
        if (exp_wr) checkOutput("issue.mem_wdata", bus.mem_wdata, exp_wdata);
        checkOutput("issue.i_resp", bus.i_resp, 0);
        checkOutput("issue.d_resp", bus.d_resp, 0);

        for (int j = 1; j < k; j++) begin
            if (wiggle) begin
                bus.d_wdata = rand_line();
                bus.d_addr  = $urandom;
                bus.i_addr  = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold.mem_read",  bus.mem_read,  !exp_wr);
            checkOutput("hold.mem_write", bus.mem_write, exp_wr);
            checkOutput("hold.mem_addr",  bus.mem_addr,  exp_addr);
            if (exp_wr) checkOutput("hold.mem_wdata", bus.mem_wdata, exp_wdata);
        end

        rline         = rand_line();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rline;
        @(posedge clk);
        @(negedge clk);
        if (!spurious) bus.mem_resp = 1'b0;
        bus.mem_rdata = rand_line();
        if (!exp_wr) model_line = rline;
        checkOutput("resp.i_resp",    bus.i_resp,    !win_d);
        checkOutput("resp.d_resp",    bus.d_resp,    win_d);
        checkOutput("resp.rdata",     win_d ? bus.d_rdata : bus.i_rdata, model_line);
        checkOutput("resp.mem_read",  bus.mem_read,  0);
        checkOutput("resp.mem_write", bus.mem_write, 0);

        @(posedge clk);
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check_quiet("idle");
    endtask

    initial begin
        logic [LINE_W-1:0] beef;
        int                v0;
        compared      = 0;
        mismatched    = 0;
        viol_count    = 0;
        rst           = 1'b1;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyReset();

        // Stray memory response while idle must be ignored.
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rand_line();
        @(posedge clk);
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check_quiet("spurious_idle");
        @(posedge clk);
        @(negedge clk);
        check_quiet("spurious_idle2");

        applyStimulus(1, 32'h0000_1234, 0, 0, 0, 0);
        do_txn(3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        beef = {8{32'hDEADBEEF}};
        applyStimulus(0, 0, 0, 1, 32'h8000_0040, beef);
        do_txn(3, 1, 0);
        applyStimulus(0, 0, 1, 0, 32'h8000_1040, rand_line());
        do_txn(2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // After reset the captured line is cleared, visible on a write response.
        applyReset();
        applyStimulus(0, 0, 0, 1, 32'h0000_0100, rand_line());
        do_txn(1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyReset();
        applyStimulus(1, 32'h0000_3000, 1, 0, 32'h0000_4000, '0);
        for (int n = 0; n < 6; n++) begin
            do_txn(1 + n % 3, 0, n == 2);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset landing mid-ISSUE must drop the memory request at once.
        applyStimulus(1, 32'h0000_5678, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset.before", bus.mem_read, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset.mem_read",  bus.mem_read,  0);
        checkOutput("midreset.mem_write", bus.mem_write, 0);
        checkOutput("midreset.i_resp",    bus.i_resp,    0);
        checkOutput("midreset.d_resp",    bus.d_resp,    0);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        model_last_d = 1'b0;
        model_line   = '0;
        do_txn(2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        v0 = viol_count;
        applyStimulus(0, 0, 1, 1, 32'h0000_2468, rand_line());
        do_txn(2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("protocol.flagged", viol_count > v0, 1);

        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 4))
                0:       applyStimulus(1, $urandom, 0, 0, $urandom, rand_line());
                1:       applyStimulus(0, $urandom, 1, 0, $urandom, rand_line());
                2:       applyStimulus(0, $urandom, 0, 1, $urandom, rand_line());
                3:       applyStimulus(1, $urandom, 1, 0, $urandom, rand_line());
                default: applyStimulus(1, $urandom, 0, 1, $urandom, rand_line());
            endcase
            do_txn($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-to-one arbiter that shares the single 256-bit line memory port between the instruction cache (read-only) and the data cache (read/write-back). It sits between the caches' downward-facing ports and the memory / burst unit. It latches one complete line transaction at grant and holds it stable toward memory until the response. It returns the response to the owning cache only, and alternates grants round-robin when both caches request.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits; line offset = log2(LINE_W/8) = 5 bits
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- i_addr  in  ADDR_W  I-cache line address
- i_read  in  1  I-cache read request, level, held until i_resp
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_addr  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache read (allocate) request, level
- d_write  in  1  D-cache write-back request, level
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_addr  out  ADDR_W  memory line address, low 5 bits forced 0
- mem_read  out  1  memory read, held until mem_resp
- mem_write  out  1  memory write, held until mem_resp
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: evaluate i_req = i_read and d_req = d_read | d_write.
  - Only one requests: grant it.
  - Both request: grant the requester not recorded in last_grant.
  - Neither requests: stay in IDLE.
  - On grant, latch the owner, op (write if d_write, else read), {addr[31:5],5'b0} and d_wdata (write only), update last_grant, then go to ISSUE.
- D-cache read and write both high: treated as write. The bench flags this as a protocol violation.
- ISSUE:
  - mem_read/mem_write are driven from the latched op; mem_addr and mem_wdata are driven from the latched registers.
  - Requester inputs are ignored.
  - On mem_resp: capture mem_rdata (read op only), then go to RESP.
- RESP:
  - The owner's resp is high for exactly this cycle, and its rdata equals the captured line.
  - The other requester's resp stays 0.
  - Next state is IDLE unconditionally. This allows the requester one cycle to drop or change its request.
- i_rdata and d_rdata both present the single captured line register. Contents are meaningful only while the matching resp is high.
- Write ops return resp with rdata unchanged from the previous capture.
- mem_resp outside ISSUE is ignored.

## Timing
- Reset (asynchronous) forces state IDLE, last_grant = I, and clears the latched addr/wdata/rdata. Consequently the first tie goes to D.
- All outputs are 0 in reset and IDLE.
- Request first sampled high in IDLE at cycle t:
  - mem_read/mem_write are high from cycle t+1.
  - mem_resp at cycle t+k (k>=1) drops mem_read/mem_write at t+k+1.
  - Owner resp is high at t+k+1.
  - Arbiter is back in IDLE at t+k+2.
- Arbiter overhead is 2 cycles beyond memory latency.
- A new request held high in the RESP cycle is sampled in IDLE the next cycle. A D-cache write-back immediately followed by its allocate read re-arbitrates, so a pending I-cache request wins that slot.
- Starvation bound: a request held continuously is granted within one other transaction.
- Reset mid-transaction: the memory request drops asynchronously and no resp is issued. The memory model must discard the in-flight op.
- mem_addr, mem_wdata and the op remain constant for the whole ISSUE interval, even if the cache's inputs change.

## Structure
- Shared package `cache_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, RESP}
  - requester enum `arb_id_t` {ARB_I, ARB_D}
  - `LINE_OFFSET_W` = 5
- No sub-module. Grant selection is a few gates and lives inline with the FSM.

## Test plan
- I-only read of 0x0000_1234, memory latency 3: mem_addr = 0x0000_1220 and mem_read from t+1; i_resp at t+4 with the memory line; d_resp stays 0.
- D write-back of 0x8000_0040 with wdata = {8{32'hDEADBEEF}}, followed by a read of 0x8000_1040: two separate memory transactions. mem_wdata is stable for the whole ISSUE, even though d_wdata changes mid-transaction.
- Simultaneous i_read and d_read from reset: D granted first and I second; then with both re-requesting, grants alternate D, I, D, I across 4 transactions.
- Spurious mem_resp pulse in IDLE and in RESP: no state change and no resp to either cache.
- rst asserted during ISSUE with mem_read high: mem_read and all resp drop in the same cycle; after release, a held i_read is re-granted and completes normally.
- d_read and d_write both high: memory sees a write and the bench protocol assertion fires.
